// File: rtl/opl3_host_master_if.sv
// Request/response stream plus OPL3 host pins for opl3_host_master; master = initiator side, slave = environment side.
interface opl3_host_master_if #(
    parameter int REG_FILE_DATA_WIDTH = 8
) ();
    logic                           req_valid;
    logic                           req_ready;
    logic                           req_rd;
    logic                           req_bank;
    logic [REG_FILE_DATA_WIDTH-1:0] req_reg;
    logic [REG_FILE_DATA_WIDTH-1:0] req_data;
    logic                           rsp_valid;
    logic [REG_FILE_DATA_WIDTH-1:0] rsp_status;
    logic                           cs_n;
    logic                           rd_n;
    logic                           wr_n;
    logic [1:0]                     address;
    logic [REG_FILE_DATA_WIDTH-1:0] bus_wdata;
    logic [REG_FILE_DATA_WIDTH-1:0] bus_rdata;

    modport master (
        input  req_valid, req_rd, req_bank, req_reg, req_data, bus_rdata,
        output req_ready, rsp_valid, rsp_status, cs_n, rd_n, wr_n, address, bus_wdata
    );

    modport slave (
        output req_valid, req_rd, req_bank, req_reg, req_data, bus_rdata,
        input  req_ready, rsp_valid, rsp_status, cs_n, rd_n, wr_n, address, bus_wdata
    );
endinterface

// File: rtl/opl3_host_master.sv
// OPL3 host initiator: each request becomes a timed cs_n/wr_n/rd_n sequence (write = address then data phase, read = status).
// Latency: write busy 2*(SETUP+STROBE+1)+ADDR_WAIT+DATA_WAIT cycles, read SETUP+STROBE+1; req_ready only while idle.
module opl3_host_master #(
    parameter int REG_FILE_DATA_WIDTH = 8,
    parameter int SETUP_CYCLES        = 1,
    parameter int STROBE_CYCLES       = 2,
    parameter int ADDR_WAIT_CYCLES    = 4,
    parameter int DATA_WAIT_CYCLES    = 4
) (
    input logic                clk,
    input logic                ic_n,
    opl3_host_master_if.master bus
);
    localparam int W      = REG_FILE_DATA_WIDTH;
    localparam int MAX_SS = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_WW = (ADDR_WAIT_CYCLES > DATA_WAIT_CYCLES) ? ADDR_WAIT_CYCLES : DATA_WAIT_CYCLES;
    localparam int MAX_P  = (MAX_SS > MAX_WW) ? MAX_SS : MAX_WW;
    localparam int CW     = $clog2(MAX_P + 1);

    typedef enum logic [3:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, A_WAIT,
        D_SETUP, D_STROBE, D_HOLD, D_WAIT,
        R_SETUP, R_STROBE, R_HOLD
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           accept, last;
    logic           bank_q, cur_bank;
    logic [W-1:0]   reg_q, data_q, cur_reg, cur_data;
    logic           cs_n_q, rd_n_q, wr_n_q, rsp_valid_q;
    logic           cs_n_d, rd_n_d, wr_n_d, rsp_valid_d;
    logic [1:0]     address_q, address_d;
    logic [W-1:0]   wdata_q, wdata_d, status_q;

    assign accept   = (state == IDLE) && bus.req_valid;
    assign last     = (cnt == '0);
    assign cur_bank = accept ? bus.req_bank : bank_q;
    assign cur_reg  = accept ? bus.req_reg  : reg_q;
    assign cur_data = accept ? bus.req_data : data_q;

    // Counter holds remaining cycles minus one in the current state.
    function automatic logic [CW-1:0] load_val(input state_t s);
        case (s)
            A_SETUP, D_SETUP, R_SETUP:    return CW'(SETUP_CYCLES - 1);
            A_STROBE, D_STROBE, R_STROBE: return CW'(STROBE_CYCLES - 1);
            A_WAIT:                       return CW'((ADDR_WAIT_CYCLES > 0) ? ADDR_WAIT_CYCLES - 1 : 0);
            D_WAIT:                       return CW'((DATA_WAIT_CYCLES > 0) ? DATA_WAIT_CYCLES - 1 : 0);
            default:                      return '0;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.req_valid) state_nxt = bus.req_rd ? R_SETUP : A_SETUP;
            A_SETUP:  if (last) state_nxt = A_STROBE;
            A_STROBE: if (last) state_nxt = A_HOLD;
            A_HOLD:   state_nxt = (ADDR_WAIT_CYCLES > 0) ? A_WAIT : D_SETUP;
            A_WAIT:   if (last) state_nxt = D_SETUP;
            D_SETUP:  if (last) state_nxt = D_STROBE;
            D_STROBE: if (last) state_nxt = D_HOLD;
            D_HOLD:   state_nxt = (DATA_WAIT_CYCLES > 0) ? D_WAIT : IDLE;
            D_WAIT:   if (last) state_nxt = IDLE;
            R_SETUP:  if (last) state_nxt = R_STROBE;
            R_STROBE: if (last) state_nxt = R_HOLD;
            R_HOLD:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase

        if (state_nxt != state) cnt_nxt = load_val(state_nxt);
        else if (!last)         cnt_nxt = cnt - CW'(1);
        else                    cnt_nxt = cnt;
    end

    // Pins are decoded from the next state so they change on the same edge as the state register.
    always_comb begin
        cs_n_d      = 1'b1;
        rd_n_d      = 1'b1;
        wr_n_d      = 1'b1;
        rsp_valid_d = 1'b0;
        address_d   = address_q;
        wdata_d     = wdata_q;
        case (state_nxt)
            A_SETUP, A_STROBE, A_HOLD: begin
                cs_n_d    = 1'b0;
                wr_n_d    = (state_nxt != A_STROBE);
                address_d = {cur_bank, 1'b0};
                wdata_d   = cur_reg;
            end
            D_SETUP, D_STROBE, D_HOLD: begin
                cs_n_d    = 1'b0;
                wr_n_d    = (state_nxt != D_STROBE);
                address_d = {cur_bank, 1'b1};
                wdata_d   = cur_data;
            end
            R_SETUP, R_STROBE, R_HOLD: begin
                cs_n_d      = 1'b0;
                rd_n_d      = (state_nxt != R_STROBE);
                rsp_valid_d = (state_nxt == R_HOLD);
                address_d   = 2'b00;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge ic_n) begin
        if (!ic_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bank_q      <= 1'b0;
            reg_q       <= '0;
            data_q      <= '0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            address_q   <= 2'b00;
            wdata_q     <= '0;
            status_q    <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            if (accept) begin
                bank_q <= bus.req_bank;
                reg_q  <= bus.req_reg;
                data_q <= bus.req_data;
            end
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            rsp_valid_q <= rsp_valid_d;
            address_q   <= address_d;
            wdata_q     <= wdata_d;
            if (state == R_STROBE && last) status_q <= bus.bus_rdata;
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_status = status_q;
    assign bus.cs_n       = cs_n_q;
    assign bus.rd_n       = rd_n_q;
    assign bus.wr_n       = wr_n_q;
    assign bus.address    = address_q;
    assign bus.bus_wdata  = wdata_q;
endmodule

// File: tb/tb_opl3_host_master.sv
// Randomized bench for opl3_host_master: pin monitor with an OPL3 register model, timing rules from the parameters.
module tb_opl3_host_master;
    localparam int W       = 8;
    localparam int SU      = 1;
    localparam int ST      = 2;
    localparam int AW      = 4;
    localparam int DW      = 4;
    localparam int WR_BUSY = 2 * (SU + ST + 1) + AW + DW;
    localparam int RD_BUSY = SU + ST + 1;
    localparam int NW_BUSY = 2 * (SU + ST + 1);

    logic clk  = 1'b0;
    logic ic_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    opl3_host_master_if #(.REG_FILE_DATA_WIDTH(W)) bus_if ();
    opl3_host_master_if #(.REG_FILE_DATA_WIDTH(W)) nw_if ();

    opl3_host_master #(
        .REG_FILE_DATA_WIDTH(W), .SETUP_CYCLES(SU), .STROBE_CYCLES(ST),
        .ADDR_WAIT_CYCLES(AW), .DATA_WAIT_CYCLES(DW)
    ) dut (.clk(clk), .ic_n(ic_n), .bus(bus_if));

    opl3_host_master #(
        .REG_FILE_DATA_WIDTH(W), .SETUP_CYCLES(SU), .STROBE_CYCLES(ST),
        .ADDR_WAIT_CYCLES(0), .DATA_WAIT_CYCLES(0)
    ) dut_nw (.clk(clk), .ic_n(ic_n), .bus(nw_if));

    int ovl_viol = 0, edge_viol = 0;
    int wr_run = 0, rd_run = 0, cs_hi = 0, rdy_lo = 0, rdy_hi = 0;
    bit p_cs = 1, p_wr = 1, p_rd = 1, p_rdy = 1;
    int wr_w_q[$], rd_w_q[$], gap_q[$], busy_q[$], hi_q[$];
    logic [9:0] ev_q[$];
    logic [7:0] rsp_q[$];
    logic [1:0] rd_addr_q[$];
    logic [1:0] rd_addr_last;
    logic [7:0] opl_regs [2][256];
    logic [7:0] exp_regs [2][256];
    bit         m_bank;
    logic [7:0] m_idx;

    // Bus monitor for the default-parameter instance; feeds a chip-side register model.
    always @(negedge clk) begin
        if (!bus_if.wr_n && !bus_if.rd_n) ovl_viol++;
        if (bus_if.cs_n && (!bus_if.wr_n || !bus_if.rd_n)) ovl_viol++;
        if (p_cs && !bus_if.cs_n && (!bus_if.wr_n || !bus_if.rd_n)) edge_viol++;
        if (!p_cs && bus_if.cs_n && (!p_wr || !p_rd)) edge_viol++;
        if (!bus_if.wr_n) wr_run++;
        else if (!p_wr) begin
            wr_w_q.push_back(wr_run);
            wr_run = 0;
            ev_q.push_back({bus_if.address, bus_if.bus_wdata});
            if (!bus_if.address[0]) begin
                m_bank = bus_if.address[1];
                m_idx  = bus_if.bus_wdata;
            end else opl_regs[m_bank][m_idx] = bus_if.bus_wdata;
        end
        if (!bus_if.rd_n) begin
            rd_run++;
            rd_addr_last = bus_if.address;
        end else if (!p_rd) begin
            rd_w_q.push_back(rd_run);
            rd_addr_q.push_back(rd_addr_last);
            rd_run = 0;
        end
        if (bus_if.cs_n) cs_hi++;
        else begin
            if (p_cs) gap_q.push_back(cs_hi);
            cs_hi = 0;
        end
        if (bus_if.req_ready) begin
            if (!p_rdy) begin busy_q.push_back(rdy_lo); rdy_lo = 0; end
            rdy_hi++;
        end else begin
            if (p_rdy) begin hi_q.push_back(rdy_hi); rdy_hi = 0; end
            rdy_lo++;
        end
        if (bus_if.rsp_valid) rsp_q.push_back(bus_if.rsp_status);
        p_cs  = bus_if.cs_n;
        p_wr  = bus_if.wr_n;
        p_rd  = bus_if.rd_n;
        p_rdy = bus_if.req_ready;
    end

    task automatic clear_mon();
        wr_w_q.delete(); rd_w_q.delete(); gap_q.delete(); busy_q.delete(); hi_q.delete();
        ev_q.delete(); rsp_q.delete(); rd_addr_q.delete();
        ovl_viol = 0; edge_viol = 0;
    endtask

    task automatic issue(input bit rd, input bit bank, input logic [7:0] r, input logic [7:0] d, output bit acc);
        bus_if.req_valid = 1'b1;
        bus_if.req_rd    = rd;
        bus_if.req_bank  = bank;
        bus_if.req_reg   = r;
        bus_if.req_data  = d;
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            if (bus_if.req_ready) acc = 1'b1;
        end
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        bus_if.req_bank  = 1'($urandom);
        bus_if.req_reg   = 8'($urandom);
        bus_if.req_data  = 8'($urandom);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus_if.req_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int active;
        ic_n = 1'b1;
        bus_if.req_valid = 1'b1; bus_if.req_rd = 1'b0; bus_if.req_bank = 1'b1;
        bus_if.req_reg = 8'h12; bus_if.req_data = 8'h34; bus_if.bus_rdata = 8'h00;
        nw_if.req_valid = 1'b0; nw_if.req_rd = 1'b0; nw_if.req_bank = 1'b0;
        nw_if.req_reg = 8'h00; nw_if.req_data = 8'h00; nw_if.bus_rdata = 8'h00;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 256; r++) begin
                opl_regs[b][r] = 8'h00;
                exp_regs[b][r] = 8'h00;
            end
        #1 ic_n = 1'b0;
        active = 0;
        repeat (5) begin
            @(negedge clk);
            if (!bus_if.cs_n || !bus_if.wr_n || !bus_if.rd_n) active++;
        end
        checks++; if (active !== 0) begin errors++; $display("FAIL reset_no_txn: active cycles %0d want 0", active); end
        checks++; if (bus_if.cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", bus_if.cs_n); end
        checks++; if (bus_if.rd_n !== 1'b1) begin errors++; $display("FAIL reset_rd_n: got %b want 1", bus_if.rd_n); end
        checks++; if (bus_if.wr_n !== 1'b1) begin errors++; $display("FAIL reset_wr_n: got %b want 1", bus_if.wr_n); end
        checks++; if (bus_if.address !== 2'd0) begin errors++; $display("FAIL reset_address: got %0d want 0", bus_if.address); end
        checks++; if (bus_if.bus_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h want 00", bus_if.bus_wdata); end
        checks++; if (bus_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus_if.rsp_valid); end
        checks++; if (bus_if.rsp_status !== 8'h00) begin errors++; $display("FAIL reset_rsp_status: got %h want 00", bus_if.rsp_status); end
        checks++; if (bus_if.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus_if.req_ready); end
        bus_if.req_valid = 1'b0;
        ic_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_write(input bit bank, input logic [7:0] r, input logic [7:0] d);
        bit acc, ok;
        clear_mon();
        issue(1'b0, bank, r, d, acc);
        wait_idle(ok);
        exp_regs[bank][r] = d;
        checks++; if (!acc || !ok) begin errors++; $display("FAIL write_b%0d_handshake: accepted %b idle %b want 1 1", bank, acc, ok); end
        checks++;
        if (ev_q.size() != 2 || ev_q[0] !== {bank, 1'b0, r} || ev_q[1] !== {bank, 1'b1, d}) begin
            errors++;
            $display("FAIL write_b%0d_events: got n=%0d %h %h want %h %h", bank, ev_q.size(),
                     ev_q.size() > 0 ? ev_q[0] : 10'h0, ev_q.size() > 1 ? ev_q[1] : 10'h0, {bank, 1'b0, r}, {bank, 1'b1, d});
        end
        checks++;
        if (wr_w_q.size() != 2 || wr_w_q[0] != ST || wr_w_q[1] != ST) begin
            errors++; $display("FAIL write_b%0d_strobe_width: got n=%0d want 2 pulses of %0d", bank, wr_w_q.size(), ST);
        end
        checks++;
        if (gap_q.size() != 2 || gap_q[1] != AW) begin
            errors++; $display("FAIL write_b%0d_addr_wait: got n=%0d last=%0d want %0d", bank, gap_q.size(),
                               gap_q.size() > 0 ? gap_q[gap_q.size()-1] : -1, AW);
        end
        checks++;
        if (busy_q.size() != 1 || busy_q[0] != WR_BUSY) begin
            errors++; $display("FAIL write_b%0d_busy: got n=%0d first=%0d want %0d", bank, busy_q.size(),
                               busy_q.size() > 0 ? busy_q[0] : -1, WR_BUSY);
        end
        checks++; if (opl_regs[bank][r] !== d) begin errors++; $display("FAIL write_b%0d_regmodel: got %h want %h", bank, opl_regs[bank][r], d); end
        checks++; if (ovl_viol != 0 || edge_viol != 0) begin errors++; $display("FAIL write_b%0d_strobe_rules: overlap %0d edge %0d want 0 0", bank, ovl_viol, edge_viol); end
    endtask

    task automatic test_read(input logic [7:0] val);
        bit acc, ok;
        clear_mon();
        bus_if.bus_rdata = 8'h5A;
        issue(1'b1, 1'($urandom), 8'($urandom), 8'($urandom), acc);
        @(posedge clk); #1; bus_if.bus_rdata = 8'h11;
        @(posedge clk); #1; bus_if.bus_rdata = val;
        @(posedge clk); #1; bus_if.bus_rdata = 8'hEE;
        checks++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_status !== val) begin
            errors++; $display("FAIL read_rsp_timing: valid %b status %h want 1 %h", bus_if.rsp_valid, bus_if.rsp_status, val);
        end
        wait_idle(ok);
        checks++; if (!acc || !ok) begin errors++; $display("FAIL read_handshake: accepted %b idle %b want 1 1", acc, ok); end
        checks++; if (rsp_q.size() != 1 || rsp_q[0] !== val) begin
            errors++; $display("FAIL read_rsp: got n=%0d status %h want 1 pulse %h", rsp_q.size(), rsp_q.size() > 0 ? rsp_q[0] : 8'h0, val);
        end
        checks++; if (rd_w_q.size() != 1 || rd_w_q[0] != ST || rd_addr_q[0] !== 2'd0) begin
            errors++; $display("FAIL read_strobe: got n=%0d width %0d want 1 pulse of %0d at address 0", rd_w_q.size(), rd_w_q.size() > 0 ? rd_w_q[0] : -1, ST);
        end
        checks++; if (busy_q.size() != 1 || busy_q[0] != RD_BUSY) begin
            errors++; $display("FAIL read_busy: got n=%0d first=%0d want %0d", busy_q.size(), busy_q.size() > 0 ? busy_q[0] : -1, RD_BUSY);
        end
        checks++; if (wr_w_q.size() != 0 || ovl_viol != 0 || edge_viol != 0) begin
            errors++; $display("FAIL read_strobe_rules: writes %0d overlap %0d edge %0d want 0 0 0", wr_w_q.size(), ovl_viol, edge_viol);
        end
    endtask

    task automatic test_back_to_back();
        bit         bb [3];
        logic [7:0] rr [3];
        logic [7:0] dd [3];
        bit         acc, ok;
        clear_mon();
        for (int k = 0; k < 3; k++) begin
            bb[k] = 1'($urandom); rr[k] = 8'($urandom); dd[k] = 8'($urandom);
        end
        bus_if.req_valid = 1'b1; bus_if.req_rd = 1'b0;
        bus_if.req_bank = bb[0]; bus_if.req_reg = rr[0]; bus_if.req_data = dd[0];
        for (int k = 0; k < 3; k++) begin
            acc = 1'b0;
            for (int i = 0; i < 100 && !acc; i++) begin
                @(negedge clk);
                if (bus_if.req_ready) acc = 1'b1;
            end
            checks++; if (!acc) begin errors++; $display("FAIL b2b_accept%0d: accepted %b want 1", k, acc); end
            @(posedge clk); #1;
            if (k < 2) begin
                bus_if.req_bank = bb[k+1]; bus_if.req_reg = rr[k+1]; bus_if.req_data = dd[k+1];
            end else bus_if.req_valid = 1'b0;
        end
        wait_idle(ok);
        for (int k = 0; k < 3; k++) exp_regs[bb[k]][rr[k]] = dd[k];
        checks++; if (!ok || hi_q.size() != 3 || hi_q[1] != 1 || hi_q[2] != 1) begin
            errors++; $display("FAIL b2b_ready_gap: got n=%0d idle cycles between txns want 1", hi_q.size());
        end
        checks++; if (busy_q.size() != 3 || busy_q[0] != WR_BUSY || busy_q[1] != WR_BUSY || busy_q[2] != WR_BUSY) begin
            errors++; $display("FAIL b2b_busy: got n=%0d want 3 x %0d", busy_q.size(), WR_BUSY);
        end
        checks++; if (gap_q.size() != 6 || gap_q[1] != AW || gap_q[2] != DW + 1 || gap_q[3] != AW || gap_q[4] != DW + 1 || gap_q[5] != AW) begin
            errors++; $display("FAIL b2b_cs_gaps: got n=%0d want 6 falls with gaps %0d/%0d", gap_q.size(), AW, DW + 1);
        end
        checks++; if (ev_q.size() != 6 || ev_q[2] !== {bb[1], 1'b0, rr[1]} || ev_q[5] !== {bb[2], 1'b1, dd[2]}) begin
            errors++; $display("FAIL b2b_events: got n=%0d want 6 in request order", ev_q.size());
        end
        for (int k = 0; k < 3; k++) begin
            checks++; if (opl_regs[bb[k]][rr[k]] !== exp_regs[bb[k]][rr[k]]) begin
                errors++; $display("FAIL b2b_regmodel%0d: got %h want %h", k, opl_regs[bb[k]][rr[k]], exp_regs[bb[k]][rr[k]]);
            end
        end
        checks++; if (ovl_viol != 0 || edge_viol != 0) begin errors++; $display("FAIL b2b_strobe_rules: overlap %0d edge %0d want 0 0", ovl_viol, edge_viol); end
    endtask

    task automatic test_random();
        bit         rd, bank, acc, ok;
        logic [7:0] r, d, rv;
        int         want;
        for (int n = 0; n < 12; n++) begin
            clear_mon();
            rd = ($urandom_range(0, 2) == 0);
            bank = 1'($urandom); r = 8'($urandom); d = 8'($urandom); rv = 8'($urandom);
            bus_if.bus_rdata = rv;
            issue(rd, bank, r, d, acc);
            wait_idle(ok);
            want = rd ? RD_BUSY : WR_BUSY;
            checks++; if (!acc || !ok || busy_q.size() != 1 || busy_q[0] != want) begin
                errors++; $display("FAIL rand%0d_busy: got n=%0d first=%0d want %0d", n, busy_q.size(), busy_q.size() > 0 ? busy_q[0] : -1, want);
            end
            if (rd) begin
                checks++; if (rsp_q.size() != 1 || rsp_q[0] !== rv) begin
                    errors++; $display("FAIL rand%0d_read: got n=%0d status %h want %h", n, rsp_q.size(), rsp_q.size() > 0 ? rsp_q[0] : 8'h0, rv);
                end
            end else begin
                exp_regs[bank][r] = d;
                checks++; if (opl_regs[bank][r] !== exp_regs[bank][r] || rsp_q.size() != 0) begin
                    errors++; $display("FAIL rand%0d_write: got %h rsp %0d want %h rsp 0", n, opl_regs[bank][r], rsp_q.size(), exp_regs[bank][r]);
                end
            end
            checks++; if (ovl_viol != 0 || edge_viol != 0) begin errors++; $display("FAIL rand%0d_strobe_rules: overlap %0d edge %0d want 0 0", n, ovl_viol, edge_viol); end
        end
    endtask

    task automatic test_no_wait();
        int busy;
        bit acc, done;
        nw_if.req_valid = 1'b1; nw_if.req_rd = 1'b0;
        nw_if.req_bank = 1'($urandom); nw_if.req_reg = 8'($urandom); nw_if.req_data = 8'($urandom);
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (nw_if.req_ready) acc = 1'b1;
        end
        @(posedge clk); #1;
        nw_if.req_valid = 1'b0;
        busy = 0; done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (nw_if.req_ready) done = 1'b1; else busy++;
        end
        checks++; if (!acc || !done || busy != NW_BUSY) begin
            errors++; $display("FAIL nowait_busy: got %0d (accepted %b idle %b) want %0d", busy, acc, done, NW_BUSY);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        bit acc, seen;
        int bad;
        nw_if.req_valid = 1'b1; nw_if.req_rd = 1'b0;
        nw_if.req_bank = 1'b1; nw_if.req_reg = 8'h40; nw_if.req_data = 8'h3F;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (nw_if.req_ready) acc = 1'b1;
        end
        @(posedge clk); #1;
        nw_if.req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (!nw_if.wr_n) seen = 1'b1;
        end
        checks++; if (!acc || !seen) begin errors++; $display("FAIL abort_strobe_seen: accepted %b strobe %b want 1 1", acc, seen); end
        #1 ic_n = 1'b0;
        #1;
        checks++; if (nw_if.wr_n !== 1'b1 || nw_if.cs_n !== 1'b1) begin
            errors++; $display("FAIL abort_async: wr_n %b cs_n %b want 1 1", nw_if.wr_n, nw_if.cs_n);
        end
        checks++; if (nw_if.req_ready !== 1'b1 || nw_if.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL abort_state: ready %b rsp_valid %b want 1 0", nw_if.req_ready, nw_if.rsp_valid);
        end
        @(posedge clk);
        @(negedge clk);
        ic_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!nw_if.cs_n || !nw_if.wr_n || nw_if.rsp_valid) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL abort_no_data_phase: active cycles %0d want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_single_write(1'b0, 8'h05, 8'h01);
        test_single_write(1'b1, 8'hBD, 8'h3F);
        test_read(8'hA0);
        test_back_to_back();
        test_random();
        test_no_wait();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/opl3_host_master.md
Name: opl3_host_master

Overview:
- Bus initiator that drives the OPL3 host interface (cs_n/rd_n/wr_n/address/data) from a simple valid/ready request stream.
- Converts each register write into the two-phase OPL3 sequence: an address write to port 0 or 2, then a data write to port 1 or 3.
- Performs status reads from port 0.
- Sits between a playback/command sequencer or CPU bridge and the opl3 host pins. All bus timing (setup, strobe width, post-write waits) is enforced here.

Parameters:
- REG_FILE_DATA_WIDTH, 8, width of register address, data and status.
- SETUP_CYCLES, 1, cycles with cs_n low and address/data valid before the strobe; must be >= 1.
- STROBE_CYCLES, 2, width of the wr_n/rd_n low pulse; must be >= 1.
- ADDR_WAIT_CYCLES, 4, idle cycles (cs_n high) after the address phase; 0 allowed.
- DATA_WAIT_CYCLES, 4, idle cycles after the data phase; 0 allowed.

Ports:
- clk  in  1  block clock
- ic_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, request accepted when valid & ready at a clk edge
- req_rd  in  1  1 = status read, 0 = register write
- req_bank  in  1  register bank (0 or 1)
- req_reg  in  REG_FILE_DATA_WIDTH  register address
- req_data  in  REG_FILE_DATA_WIDTH  register write data
- rsp_valid  out  1  one-cycle pulse, rsp_status valid
- rsp_status  out  REG_FILE_DATA_WIDTH  captured status byte
- cs_n  out  1  OPL3 chip select
- rd_n  out  1  OPL3 read strobe
- wr_n  out  1  OPL3 write strobe
- address  out  2  OPL3 port select
- bus_wdata  out  REG_FILE_DATA_WIDTH  data to OPL3 din
- bus_rdata  in  REG_FILE_DATA_WIDTH  data from OPL3 dout

Behaviour:
- Reset (ic_n low, asynchronous, immediate): state IDLE, cs_n=1, rd_n=1, wr_n=1, address=0, bus_wdata=0, rsp_valid=0, rsp_status=0, counter=0, req_ready=1.
- All bus outputs are registered, Moore-decoded from the state. No combinational path from req_* to bus pins.
- A request is captured into internal registers on acceptance. req_* may change afterward.
- Write FSM, entered the cycle after acceptance:
  - A_SETUP (SETUP_CYCLES): cs_n=0, wr_n=1, address={req_bank,0}, bus_wdata=req_reg.
  - A_STROBE (STROBE_CYCLES): wr_n=0, other outputs held.
  - A_HOLD (1 cycle): wr_n=1, cs_n=0.
  - A_WAIT (ADDR_WAIT_CYCLES): cs_n=1. Skipped when the parameter is 0.
  - D_SETUP/D_STROBE/D_HOLD: same timing as the address phase, with address={req_bank,1} and bus_wdata=req_data.
  - D_WAIT (DATA_WAIT_CYCLES): cs_n=1. Skipped when 0.
  - Then IDLE.
- Read FSM:
  - R_SETUP (SETUP_CYCLES): cs_n=0, address=0.
  - R_STROBE (STROBE_CYCLES): rd_n=0. bus_rdata is sampled into rsp_status on the final strobe cycle.
  - R_HOLD (1 cycle): rd_n=1, rsp_valid=1.
  - Then IDLE.
  - req_bank, req_reg and req_data are ignored for reads.
  - Reads have no post-wait.
- req_ready=1 only in IDLE, so exactly one request is outstanding.
- Back-to-back requests: the next request can be accepted on the first IDLE cycle. There is a 1-cycle idle gap (cs_n=1) between transactions.
- Busy duration:
  - Write: 2*(SETUP+STROBE+1)+ADDR_WAIT+DATA_WAIT cycles. With defaults this is 16.
  - Read: SETUP+STROBE+1 cycles. With defaults this is 4.
- rd_n and wr_n are never low simultaneously.
- rd_n/wr_n never fall in the same cycle cs_n falls, and never rise in the same cycle cs_n rises.
- Wait counter: down-counter of width $clog2(max param+1), reloaded on each state entry.
- Reset mid-transaction: aborts immediately. Strobes and cs_n go high asynchronously. No response is issued and the request is lost.

Test Plan:
- Reset: hold ic_n low with req_valid=1 -> cs_n=rd_n=wr_n=1, address=0, rsp_valid=0, req_ready=1, and no transaction starts until ic_n is released.
- Bank-0 write, reg 0x05 data 0x01, defaults -> address=0 with bus_wdata=0x05 and wr_n low for 2 cycles; then 4 cycles with cs_n=1; then address=1 with bus_wdata=0x01 and wr_n low for 2 cycles; req_ready low for exactly 16 cycles.
- Bank-1 write, reg 0xBD data 0x3F -> address=2 then address=3 with matching bus_wdata; an OPL3 register model shows bank-1 reg 0xBD = 0x3F.
- Status read with bus_rdata=0xA0 -> rd_n low for 2 cycles at address=0; rsp_valid pulses once with rsp_status=0xA0; req_ready low for 4 cycles.
- req_valid held high with 3 queued writes -> each accepted on the first ready cycle; a 1-cycle cs_n-high gap between transactions; no strobe overlap.
- ADDR_WAIT_CYCLES=0 and DATA_WAIT_CYCLES=0 -> write busy for 8 cycles. ic_n pulsed low mid A_STROBE -> wr_n and cs_n high in the same cycle, and no data phase follows.
